// File: rtl/fruit_pkg.sv
// fruit_pkg: shared widths, fruit type codes, LFSR mask and the spawn request type
package fruit_pkg;
  localparam int LANE_W = 3;
  localparam int TYPE_W = 2;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  typedef enum logic [TYPE_W-1:0] {
    TYPE_APPLE = 2'd0,
    TYPE_PEAR  = 2'd1,
    TYPE_GOLD  = 2'd2,
    TYPE_BOMB  = 2'd3
  } fruit_type_e;
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    fruit_type_e       ftype;
  } spawn_req_t;
endpackage

// File: rtl/spawn_fifo.sv
// spawn_fifo: spawn_req_t queue with a registered head, full/empty flags, async active-low reset
// Ports: clk, rst_n; push/wdata write side; rd_ready/rd_valid/rd_data read handshake; full, empty.
// The head register counts toward DEPTH, so total storage is exactly DEPTH entries.
module spawn_fifo
  import fruit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  spawn_req_t wdata,
  input  logic       rd_ready,
  output logic       rd_valid,
  output spawn_req_t rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  spawn_req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] mcnt, occ;
  logic pop, ld, wr;
  assign pop   = rd_valid && rd_ready;
  // refill the head register whenever it is free or being consumed
  assign ld    = (mcnt != '0) && (!rd_valid || pop);
  assign occ   = mcnt + (AW+1)'(rd_valid);
  assign full  = occ == (AW+1)'(DEPTH);
  assign empty = occ == '0;
  assign wr    = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      mcnt     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (ld) begin
        rp      <= rp + AW'(1);
        rd_data <= mem[rp];
      end
      rd_valid <= ld ? 1'b1 : (pop ? 1'b0 : rd_valid);
      mcnt     <= mcnt + (AW+1)'(wr) - (AW+1)'(ld);
    end
  end
endmodule

// File: rtl/fruit_spawn_scheduler.sv
// fruit_spawn_scheduler: turns each tick_in toggle into a queued random fruit-spawn request
// Ports: C50 clock, resetn async active-low; tick_in toggling tick, enable game running;
// spawn_valid/spawn_ready/spawn_lane/spawn_type renderer handshake; spawn_count, drop_count, overflow stats.
module fruit_spawn_scheduler
  import fruit_pkg::*;
#(
  parameter int          NUM_LANES  = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 16
) (
  input  logic             C50,
  input  logic             resetn,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             spawn_ready,
  output logic             spawn_valid,
  output logic [2:0]       spawn_lane,
  output logic [1:0]       spawn_type,
  output logic [CNT_W-1:0] spawn_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [2:0]  NL   = 3'(NUM_LANES);
  logic s1, s2, s3, qev, pop, drop, push, full, prev_valid;
  logic [15:0] lfsr, lfsr_n;
  logic [2:0] raw3, raw, lane, prev_lane;
  logic [3:0] inc;
  spawn_req_t req, head;
  assign qev    = (s2 ^ s3) && enable;
  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  assign raw3   = lfsr_n[2:0];
  // one subtraction folds 0..7 into range for any NUM_LANES in 4..8
  assign raw    = (raw3 >= NL) ? raw3 - NL : raw3;
  assign inc    = {1'b0, raw} + 4'd1;
  assign lane   = (prev_valid && raw == prev_lane) ? ((inc == 4'(NUM_LANES)) ? 3'd0 : inc[2:0]) : raw;
  assign req    = '{lane: lane, ftype: fruit_type_e'(lfsr_n[5:4])};
  assign pop    = spawn_valid && spawn_ready;
  assign drop   = qev && full && !pop;
  assign push   = qev && !drop;
  assign spawn_lane = head.lane;
  assign spawn_type = head.ftype;
  spawn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (C50),
    .rst_n    (resetn),
    .push     (push),
    .wdata    (req),
    .rd_ready (spawn_ready),
    .rd_valid (spawn_valid),
    .rd_data  (head),
    .full     (full),
    .empty    ()
  );
  always_ff @(posedge C50 or negedge resetn) begin
    if (!resetn) begin
      {s1, s2, s3} <= 3'b000;
      lfsr         <= SEED;
      prev_lane    <= '0;
      prev_valid   <= 1'b0;
      spawn_count  <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      {s1, s2, s3} <= {tick_in, s1, s2};
      if (qev) begin
        lfsr       <= lfsr_n;
        prev_lane  <= lane;
        prev_valid <= 1'b1;
      end
      if (push) spawn_count <= spawn_count + CNT_W'(1);
      if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: doc/fruit_spawn_scheduler.md
Name: fruit_spawn_scheduler

Overview:
- Sits directly downstream of the speed-up tick generator.
- Consumes its toggling output level and turns every toggle (rising or falling) into one fruit-spawn request.
- Each request carries a pseudo-random lane and fruit type from a 16-bit LFSR, and never repeats the previous lane.
- Requests queue in a small FIFO and are handed to the renderer over a valid/ready handshake; the faster the tick, the faster fruit spawns.

Parameters:
- NUM_LANES, 5, number of drop lanes; legal range 4..8.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
- FIFO_DEPTH, 4, request queue depth; power of two, 2..16.
- CNT_W, 16, width of the spawn and drop counters.

Ports:
- C50  input  1  system clock, 50 MHz.
- resetn  input  1  reset, asynchronous, active-low.
- tick_in  input  1  toggling level from the speed-up tick generator; asynchronous to this block's view, so it is synchronised.
- enable  input  1  game running; when low, tick events are ignored.
- spawn_ready  input  1  renderer can accept a request.
- spawn_valid  output  1  request available at FIFO head.
- spawn_lane  output  3  lane index, 0..NUM_LANES-1.
- spawn_type  output  2  fruit type code.
- spawn_count  output  CNT_W  requests accepted into the FIFO since reset.
- drop_count  output  CNT_W  events dropped because the FIFO was full.
- overflow  output  1  sticky flag, set on the first drop.

Behaviour:
- Reset (async, resetn=0):
  - spawn_valid=0, spawn_lane=0, spawn_type=0.
  - spawn_count=0, drop_count=0, overflow=0.
  - FIFO empty; LFSR=LFSR_SEED; prev_valid=0.
  - Synchroniser flops s1/s2/s3 = 0.
- Synchronisation:
  - s1<=tick_in, s2<=s1, s3<=s2.
  - event = s2 ^ s3, so one event per toggle, in either direction.
- LFSR:
  - Galois, right-shifting, mask 16'hB400.
  - next = lsb ? (lfsr>>1)^16'hB400 : lfsr>>1.
  - Advances only on a qualified event (event && enable).
- Lane and type, computed from the NEXT LFSR value n:
  - raw = n[2:0]; if raw >= NUM_LANES then raw = raw - NUM_LANES (a single subtraction suffices for the legal range).
  - If prev_valid and raw == prev_lane, then lane = (raw+1 == NUM_LANES) ? 0 : raw+1; otherwise lane = raw.
  - type = n[5:4].
  - prev_lane and prev_valid=1 update on every qualified event, including dropped ones.
- Push:
  - A qualified event writes {lane,type} at the clock edge ending the event cycle.
  - If the FIFO is full and not popping in that cycle: the entry is discarded, drop_count increments (saturating at all-ones), and overflow is set.
  - Otherwise spawn_count increments (wrapping).
- Pop:
  - Occurs when spawn_valid && spawn_ready.
  - spawn_lane and spawn_type always show the FIFO head and hold stable while valid && !ready.
- Latency:
  - From a tick_in change before edge 0, spawn_valid rises after edge 3, provided the FIFO was empty.
  - No fall-through bypass; data is registered from the FIFO.
- Simultaneous events:
  - Push and pop in the same cycle with the FIFO full: both accepted, occupancy unchanged, no drop.
  - Push and pop with the FIFO empty: only the push takes effect, since valid was 0.
- enable low:
  - No push, no LFSR advance, no counter change.
  - The FIFO keeps draining.
  - Synchroniser flops still run, so re-enabling does not create a phantom event.
- Reset mid-operation: all queued requests are lost immediately and the LFSR restarts at the seed, so the sequence is reproducible.

Decomposition:
- Shared package fruit_pkg holds:
  - LANE_W=3, TYPE_W=2.
  - The fruit type codes: TYPE_APPLE=0, TYPE_PEAR=1, TYPE_GOLD=2, TYPE_BOMB=3.
  - LFSR_MASK=16'hB400.
  - A packed spawn_req_t type {lane,type}.
- One sub-module, spawn_fifo: a synchronous FIFO of spawn_req_t with full/empty flags and async active-low reset. It is reused by the renderer queue.

Test Plan:
- Default parameters, enable=1, spawn_ready=1, toggle tick_in 4 times spaced 10 cycles apart:
  - Expected requests, in order: (lane0,type3), (lane1,type3), (lane4,type1), (lane1,type0).
  - The second request is a repeat of lane 0 bumped to lane 1; the fourth is raw 6 reduced by NUM_LANES to 1.
  - spawn_count=4.
- Single tick_in rise at edge 0 with the FIFO empty -> spawn_valid=1 exactly after edge 3; it holds while spawn_ready=0, with lane and type stable.
- spawn_ready=0, 6 toggles -> 4 accepted, drop_count=2, overflow=1; spawn_count=4. Then ready=1 drains the 4 entries in first-generation order.
- FIFO full, with a toggle landing in the same cycle as a pop -> no drop; occupancy stays 4 and drop_count is unchanged.
- enable=0 across 3 toggles, then enable=1 and 1 toggle -> exactly one request, equal to (lane0,type3), showing the LFSR did not advance while disabled.
- Assert resetn low mid-drain with 3 entries queued -> spawn_valid=0 asynchronously. After release, the next toggle produces (lane0,type3) and all counters are 0 before that event.
